send_scheduler: RTL

Arbitrates outgoing inter-board messages from two local requesters (game-control moves and system/turn messages), buffers them in a small FIFO, and sequences `send_all` one message at a time. It sits between GameControl and `send_all`. It issues a one-cycle `ctrl_en` and holds all message fields stable until `send_all` returns to its ready state, because `send_all` samples each field later in the six-step transfer.

---
 rtl/send_scheduler_if.sv | 36 +++
 rtl/send_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/send_scheduler_if.sv
// ============================================================================
// send_scheduler_if: requester handshakes and send_all control/message fields.
// Rev 1.0
// ============================================================================
`default_nettype none

interface send_scheduler_if;
    logic        req_a_valid;
    logic [21:0] req_a_msg;
    logic        req_a_ready;
    logic        req_b_valid;
    logic [21:0] req_b_msg;
    logic        req_b_ready;
    logic        send_ready;
    logic        ctrl_en;
    logic [3:0]  ctrl_msg_type;
    logic [4:0]  ctrl_block_x;
    logic [2:0]  ctrl_block_y;
    logic [5:0]  ctrl_card;
    logic [2:0]  ctrl_sel_len;
    logic        ctrl_move_dir;

    modport master (
        output req_a_valid, req_a_msg, req_b_valid, req_b_msg, send_ready,
        input  req_a_ready, req_b_ready, ctrl_en, ctrl_msg_type, ctrl_block_x,
               ctrl_block_y, ctrl_card, ctrl_sel_len, ctrl_move_dir
    );

    modport slave (
        input  req_a_valid, req_a_msg, req_b_valid, req_b_msg, send_ready,
        output req_a_ready, req_b_ready, ctrl_en, ctrl_msg_type, ctrl_block_x,
               ctrl_block_y, ctrl_card, ctrl_sel_len, ctrl_move_dir
    );
endinterface

`default_nettype wire

// File: rtl/send_scheduler.sv
// ============================================================================
// send_scheduler: round-robin arbiter + FIFO sequencing send_all one message at a time.
// Rev 1.0
// ============================================================================
`default_nettype none

module send_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   interboard_rst_i,
    send_scheduler_if.slave        bus,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   timeout_err_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LIMIT  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [21:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                last_b_q, last_b_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                err_q, err_d;
    logic [21:0]         fields_q, fields_d;

    logic                not_full;
    logic                grant_a;
    logic                grant_b;
    logic                push;
    logic                pop;
    logic                tick;
    logic [21:0]         push_msg;

    // last_b_q set means B holds the most recent grant, so A wins the next tie.
    assign not_full = (count_q != FULL_COUNT);
    assign grant_a  = not_full & bus.req_a_valid & (~bus.req_b_valid | last_b_q);
    assign grant_b  = not_full & bus.req_b_valid & (~bus.req_a_valid | ~last_b_q);
    assign push     = (grant_a | grant_b) & ~interboard_rst_i;
    assign push_msg = grant_a ? bus.req_a_msg : bus.req_b_msg;

    assign bus.req_a_ready = grant_a & rst_ni & ~interboard_rst_i;
    assign bus.req_b_ready = grant_b & rst_ni & ~interboard_rst_i;

    always_comb begin
        state_d  = state_q;
        fields_d = fields_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        last_b_d = last_b_q;
        pop      = 1'b0;
        tick     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && bus.send_ready) begin
                    pop      = 1'b1;
                    fields_d = mem_q[rd_ptr_q];
                    tmr_d    = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                tick = 1'b1;
                if (!bus.send_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                tick = 1'b1;
                if (bus.send_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturating timer; the error flags the cycle the count lands on the limit.
        if (tick && (tmr_q != TMR_LIMIT)) begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_d == TMR_LIMIT) begin
                err_d = 1'b1;
            end
        end

        if (push) begin
            last_b_d = grant_b;
        end

        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (interboard_rst_i) begin
            state_d  = S_IDLE;
            fields_d = '0;
            tmr_d    = '0;
            err_d    = 1'b0;
            last_b_d = 1'b1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            fields_q <= '0;
            tmr_q    <= '0;
            err_q    <= 1'b0;
            last_b_q <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            last_b_q <= last_b_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_msg;
        end
    end

    assign bus.ctrl_en = (state_q == S_ISSUE);
    assign {bus.ctrl_msg_type, bus.ctrl_block_x, bus.ctrl_block_y,
            bus.ctrl_card, bus.ctrl_sel_len, bus.ctrl_move_dir} = fields_q;

    assign busy_o        = (state_q != S_IDLE);
    assign fifo_count_o  = count_q;
    assign timeout_err_o = err_q;

endmodule

`default_nettype wire
